// File: rtl/synth_i2c_pkg.sv
// ============================================================================
// Module  : synth_i2c_pkg
// Purpose : Shared types and constants for the I2C command master.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package synth_i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Frame lengths in SCL quarter-periods, measured from the accept edge.
    localparam int FRAME_FULL_Q   = 116;
    localparam int FRAME_NACK_A_Q = 44;
    localparam int FRAME_NACK_H_Q = 80;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_ADDR  = 4'd2,
        S_ACK_A = 4'd3,
        S_DHI   = 4'd4,
        S_ACK_H = 4'd5,
        S_DLO   = 4'd6,
        S_ACK_L = 4'd7,
        S_STOP  = 4'd8
    } state_t;

endpackage

`default_nettype wire

// File: rtl/i2c_cmd_master_if.sv
// ============================================================================
// Module  : i2c_cmd_master_if
// Purpose : Command handshake and open-drain line controls of the I2C master.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface i2c_cmd_master_if;
    import synth_i2c_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              sda_in;
    logic              sda_oe;
    logic              scl_oe;
    logic              busy;
    logic              done;
    logic              nack;

    modport master (
        input  cmd_valid, cmd_addr, cmd_data, sda_in,
        output cmd_ready, sda_oe, scl_oe, busy, done, nack
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_data, sda_in,
        input  cmd_ready, sda_oe, scl_oe, busy, done, nack
    );

endinterface

`default_nettype wire

// File: rtl/i2c_quarter_tick.sv
// ============================================================================
// Module  : i2c_quarter_tick
// Purpose : SCL quarter-period strobe and 2-bit phase counter, held at zero when idle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_quarter_tick
    import synth_i2c_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       en,
    output logic            tick,
    output logic [1:0]      q
);

    localparam int              CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   c_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_q;
    logic          w_last;

    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            r_cnt <= '0;
            r_q   <= Q0;
        end else if (w_last) begin
            r_cnt <= '0;
            r_q   <= r_q + 2'd1;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = en && w_last;
    assign q    = r_q;

endmodule

`default_nettype wire

// File: rtl/i2c_cmd_master.sv
// ============================================================================
// Module  : i2c_cmd_master
// Purpose : Write-only I2C master sending {addr,W}, data[15:8], data[7:0] per command.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_cmd_master
    import synth_i2c_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  wire logic        clk,
    input  wire logic        reset,
    i2c_cmd_master_if.master bus
);

    state_t              r_state;
    logic [DATA_W-1:0]   r_data;
    logic [7:0]          r_shift;
    logic [2:0]          r_bit;
    logic                r_nack_flag;
    logic                r_busy;
    logic                r_ready;
    logic                r_done;
    logic                r_nack;
    logic                r_sda_oe;
    logic                r_scl_oe;
    logic                w_tick;
    logic [1:0]          w_q;

    i2c_quarter_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (r_busy),
        .tick  (w_tick),
        .q     (w_q)
    );

    // Line controls are updated on the tick that ends a quarter, so they
    // always describe the quarter that is about to begin.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_shift     <= '0;
            r_bit       <= 3'd7;
            r_nack_flag <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_scl_oe    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_nack <= 1'b0;
            if (r_state == S_IDLE) begin
                if (bus.cmd_valid && r_ready) begin
                    r_data   <= bus.cmd_data;
                    r_shift  <= {bus.cmd_addr, 1'b0};
                    r_bit    <= 3'd7;
                    r_state  <= S_START;
                    r_busy   <= 1'b1;
                    r_ready  <= 1'b0;
                    r_sda_oe <= 1'b0;
                    r_scl_oe <= 1'b0;
                end
            end else if (w_tick) begin
                case (r_state)
                    S_START: begin
                        if (w_q == Q1) begin
                            r_sda_oe <= 1'b1;
                        end else if (w_q == Q3) begin
                            r_state  <= S_ADDR;
                            r_scl_oe <= 1'b1;
                            r_sda_oe <= ~r_shift[7];
                        end
                    end
                    S_ADDR, S_DHI, S_DLO: begin
                        if (w_q == Q1) begin
                            r_scl_oe <= 1'b0;
                        end else if (w_q == Q3) begin
                            r_scl_oe <= 1'b1;
                            r_bit    <= r_bit - 3'd1;
                            if (r_bit == 3'd0) begin
                                r_sda_oe <= 1'b0;
                                case (r_state)
                                    S_ADDR:  r_state <= S_ACK_A;
                                    S_DHI:   r_state <= S_ACK_H;
                                    default: r_state <= S_ACK_L;
                                endcase
                            end else begin
                                r_shift  <= {r_shift[6:0], 1'b0};
                                r_sda_oe <= ~r_shift[6];
                            end
                        end
                    end
                    S_ACK_A, S_ACK_H, S_ACK_L: begin
                        if (w_q == Q1) begin
                            r_scl_oe <= 1'b0;
                        end else if (w_q == Q2) begin
                            if (bus.sda_in) r_nack_flag <= 1'b1;
                        end else if (w_q == Q3) begin
                            r_scl_oe <= 1'b1;
                            if (r_nack_flag || r_state == S_ACK_L) begin
                                r_state  <= S_STOP;
                                r_sda_oe <= 1'b1;
                            end else if (r_state == S_ACK_A) begin
                                r_state  <= S_DHI;
                                r_shift  <= r_data[15:8];
                                r_sda_oe <= ~r_data[15];
                            end else begin
                                r_state  <= S_DLO;
                                r_shift  <= r_data[7:0];
                                r_sda_oe <= ~r_data[7];
                            end
                        end
                    end
                    S_STOP: begin
                        case (w_q)
                            Q0: r_scl_oe <= 1'b0;
                            Q1: r_sda_oe <= 1'b0;
                            Q3: begin
                                r_state     <= S_IDLE;
                                r_busy      <= 1'b0;
                                r_ready     <= 1'b1;
                                r_done      <= 1'b1;
                                r_nack      <= r_nack_flag;
                                r_nack_flag <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.cmd_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.nack      = r_nack;
    assign bus.sda_oe    = r_sda_oe;
    assign bus.scl_oe    = r_scl_oe;

endmodule

`default_nettype wire

// File: doc/i2c_cmd_master.md
Name: i2c_cmd_master

Overview:
- I2C master write-only transmitter; the driving end of the synth core's sda/scl slave port.
- Takes one 16-bit command word (note/control word for the synth core) over a valid/ready handshake.
- Emits one frame: START, {slave_addr, W}, data[15:8], data[7:0], STOP; checks ACK after each byte.
- Used in the chip-level bench and in the companion controller FPGA.

Parameters:
CLK_DIV, 25, system clocks per SCL quarter-period; must be >= 2. A 10 MHz clk gives 100 kHz SCL.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  block idle and able to accept
cmd_addr  in  7  target slave address
cmd_data  in  16  payload; sent MSB first
sda_in  in  1  sampled SDA line, used for ACK
sda_oe  out  1  1 = pull SDA low; 0 = release
scl_oe  out  1  1 = pull SCL low; 0 = release
busy  out  1  frame in progress
done  out  1  one-cycle pulse at end of frame
nack  out  1  one-cycle pulse, coincident with done, if any ACK slot read 1

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - sda_oe=0, scl_oe=0, busy=0, done=0, nack=0, cmd_ready=1.
  - Divider cleared, state=IDLE.
  - Reset mid-frame releases both lines on the next edge. The resulting bus glitch is accepted.
- Handshake:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - cmd_addr and cmd_data are latched at that edge. cmd_ready=0 and busy=1 from the next cycle.
  - cmd_valid while busy is ignored.
- Quarter tick:
  - A counter 0..CLK_DIV-1 runs only while busy. The tick fires on count CLK_DIV-1.
  - A 2-bit phase q advances on each tick.
- States: IDLE, START, ADDR, ACK_A, DHI, ACK_H, DLO, ACK_L, STOP.
- START (4 quarters):
  - q0,q1: both lines released.
  - q2,q3: sda_oe=1, scl released. This forms the START condition.
- Bit slot (ADDR/DHI/DLO: 8 slots each; ACK_x: 1 slot; 4 quarters per slot):
  - q0,q1: scl_oe=1.
  - q2,q3: scl_oe=0.
  - sda_oe is set at the start of q0 and is constant for the whole slot. sda_oe = ~bit.
- Bit order:
  - Address byte = {cmd_addr, 1'b0}, MSB first.
  - Then cmd_data[15:8], then cmd_data[7:0].
- ACK slot:
  - sda_oe=0 for the whole slot.
  - sda_in is sampled on the last clock of q2.
  - 0 = ACK. 1 = NACK: set a sticky nack flag.
- Transitions:
  - ADDR→ACK_A→DHI→ACK_H→DLO→ACK_L→STOP.
  - Any NACK goes from the ACK state directly to STOP. Remaining bytes are skipped.
- STOP (4 quarters):
  - q0: scl_oe=1, sda_oe=1.
  - q1: scl released, sda_oe=1.
  - q2,q3: both released. This forms the STOP condition.
- Latency (accept edge = T0; D = CLK_DIV):
  - Full frame: done=1 in the cycle starting at edge T0 + 116·D.
  - Address NACK: done=1 at T0 + 44·D.
  - High-byte NACK: done=1 at T0 + 80·D.
- End of frame:
  - In the done cycle: busy=0, cmd_ready=1. nack=1 if the sticky flag is set; the flag then clears.
  - A new command may be accepted in the done cycle. Back-to-back frames are allowed.
- SDA never changes while SCL is released, except in START and STOP.

Decomposition:
- Package synth_i2c_pkg holds:
  - state enum localparams;
  - ADDR_W=7, DATA_W=16;
  - quarter-phase constants Q0..Q3;
  - frame-length constants 116, 44, 80.
- One sub-module: i2c_quarter_tick.
  - Parameter CLK_DIV.
  - Ports: clk, reset, en, tick, q[1:0].
- The FSM and shift register stay in i2c_cmd_master.

Test Plan:
Bench uses CLK_DIV=4 with a behavioural slave model.
- Reset: assert reset mid-frame for 1 cycle → next cycle sda_oe=0, scl_oe=0, busy=0, cmd_ready=1, done=0.
- Full frame: cmd_addr=7'h2A, cmd_data=16'h4F20, slave ACKs all bytes →
  - decoded bytes 0x54, 0x4F, 0x20;
  - done at T0+464 cycles, nack=0;
  - START and STOP detected exactly once each.
- Address NACK: slave ignores 7'h11 → only byte 0x22 seen; done and nack both pulse at T0+176; STOP follows.
- Data NACK: slave NACKs the high byte of 16'hFFFF → done and nack at T0+320; no third byte.
- Busy protection and back-to-back:
  - Hold cmd_valid high with 16'h1234, then 16'h5678 queued → second command accepted exactly on the first done cycle.
  - cmd_valid pulses mid-frame are ignored.
  - Two complete frames, 928 cycles total.
- Protocol checker, all tests: SDA is stable while SCL is high outside START/STOP; SCL high and low each last 2·CLK_DIV cycles.
